booth_dot_accum: RTL and testbench

//  Consumes the signed 16-bit products of the 8x8 radix-4 Booth/Wallace multiplier.

---
 rtl/booth_dot_accum_pkg.sv | 15 +
 rtl/booth_dot_accum_sat_add_s.sv | 28 ++
 rtl/booth_dot_accum.sv | 111 +++++++++++
 tb/tb_booth_dot_accum.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_dot_accum_pkg.sv
// Shared definitions for the Booth dot-product accumulator:
// FSM state encodings and the default widths.
package booth_dot_accum_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam int DEF_PROD_W = 16;
   localparam int DEF_ACC_W  = 24;
   localparam int DEF_LEN_W  = 8;

endpackage

// File: rtl/booth_dot_accum_sat_add_s.sv
// Combinational signed saturating adder. A W+1 bit sum exposes overflow
// as a disagreement between its top two bits.
module sat_add_s #(
   parameter int W = 24
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum,
   output logic         ovf
);

   localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

   logic [W:0] sum_full;

   always_comb begin
      sum_full = {a[W-1], a} + {b[W-1], b};
      ovf      = sum_full[W] ^ sum_full[W-1];
      if (ovf) begin
         // Bit W carries the true sign of the result, which picks the rail.
         sum = sum_full[W] ? SAT_MIN : SAT_MAX;
      end else begin
         sum = sum_full[W-1:0];
      end
   end

endmodule

// File: rtl/booth_dot_accum.sv
// Accumulates a run of signed products into a saturating dot product and
// hands the result downstream over a valid/ready handshake.
module booth_dot_accum
   import booth_dot_accum_pkg::*;
#(
   parameter int PROD_W = DEF_PROD_W,
   parameter int ACC_W  = DEF_ACC_W,
   parameter int LEN_W  = DEF_LEN_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic              clear,
   input  logic              prod_valid,
   output logic              prod_ready,
   input  logic [PROD_W-1:0] prod,
   output logic              acc_valid,
   input  logic              acc_ready,
   output logic [ACC_W-1:0]  acc_out,
   output logic              acc_ovf,
   output logic              busy,
   output logic [1:0]        dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready.
   // prod_ready and acc_valid depend on state only, never on the partner's signal.

   state_t             state, state_next;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   cnt;
   logic [ACC_W-1:0]   prod_ext;
   logic [ACC_W-1:0]   add_sum;
   logic               add_ovf;
   logic               beat;
   logic               last_beat;

   assign prod_ext  = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
   assign beat      = prod_valid && prod_ready;
   assign last_beat = beat && (cnt == len_q - LEN_W'(1));
   assign dbg_state = state;

   sat_add_s #(.W(ACC_W)) u_sat_add (
      .a   (acc_out),
      .b   (prod_ext),
      .sum (add_sum),
      .ovf (add_ovf)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (clear) begin
         state_next = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  if (start) state_next = (len != '0) ? ST_ACCUM : ST_DONE;
            ST_ACCUM: if (last_beat) state_next = ST_DONE;
            ST_DONE:  if (acc_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      prod_ready = (state == ST_ACCUM);
      acc_valid  = (state == ST_DONE);
      busy       = (state == ST_ACCUM) || (state == ST_DONE);
   end

   // Datapath: acc_out doubles as the running accumulator and is frozen outside ACCUM.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_out <= '0;
         acc_ovf <= 1'b0;
         cnt     <= '0;
         len_q   <= '0;
      end else if (clear) begin
         acc_out <= '0;
         acc_ovf <= 1'b0;
         cnt     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  acc_out <= '0;
                  acc_ovf <= 1'b0;
                  cnt     <= '0;
                  len_q   <= len;
               end
            end
            ST_ACCUM: begin
               if (beat) begin
                  acc_out <= add_sum;
                  acc_ovf <= acc_ovf | add_ovf;
                  cnt     <= cnt + LEN_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_dot_accum.sv
// Bench for booth_dot_accum, built with an 18-bit accumulator so saturation is reachable in short runs.
module tb_booth_dot_accum;

   localparam int PW = 16;
   localparam int AW = 18;
   localparam int LW = 8;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACCUM = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [LW-1:0] len = '0;
   logic          clear = 1'b0;
   logic          prod_valid = 1'b0;
   logic          prod_ready;
   logic [PW-1:0] prod = '0;
   logic          acc_valid;
   logic          acc_ready = 1'b1;
   logic [AW-1:0] acc_out;
   logic          acc_ovf;
   logic          busy;
   logic [1:0]    dbg_state;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string name;
      int    n;
      int    p[10];
      bit    gap;
      int    exp_acc;
      bit    exp_ovf;
   } vec_t;

   // Expected result word: {ovf, acc}
   logic [AW:0] exp_q[$];
   vec_t        vecs[6];

   booth_dot_accum #(.PROD_W(PW), .ACC_W(AW), .LEN_W(LW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .len        (len),
      .clear      (clear),
      .prod_valid (prod_valid),
      .prod_ready (prod_ready),
      .prod       (prod),
      .acc_valid  (acc_valid),
      .acc_ready  (acc_ready),
      .acc_out    (acc_out),
      .acc_ovf    (acc_ovf),
      .busy       (busy),
      .dbg_state  (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] accv(input int v);
      logic [AW-1:0] t;
      t = AW'(v);
      return 32'(t);
   endfunction

   function automatic logic [AW:0] mk_exp(input int v, input bit o);
      logic [AW-1:0] t;
      t = AW'(v);
      return {o, t};
   endfunction

   // Scoreboard: compare every completed result handshake against the queue head.
   always @(negedge clk) begin
      if (rst_n && acc_valid && acc_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got acc=%0h ovf=%0b with nothing expected", acc_out, acc_ovf);
         end else begin
            logic [AW:0] e;
            e = exp_q.pop_front();
            check("result_acc", 32'(acc_out), 32'(e[AW-1:0]));
            check("result_ovf", 32'(acc_ovf), 32'(e[AW]));
         end
      end
   end

   task automatic run_vec(input vec_t v);
      exp_q.push_back(mk_exp(v.exp_acc, v.exp_ovf));
      start = 1'b1;
      len   = LW'(v.n);
      step();
      start = 1'b0;
      check({v.name, "_busy"}, 32'(busy), 32'd1);
      for (int i = 0; i < v.n; i++) begin
         if (v.gap && i > 0) begin
            prod_valid = 1'b0;
            step();
            check({v.name, "_ready_gap"}, 32'(prod_ready), 32'd1);
         end
         check({v.name, "_no_early_valid"}, 32'(acc_valid), 32'd0);
         prod       = PW'(v.p[i]);
         prod_valid = 1'b1;
         step();
      end
      prod_valid = 1'b0;
      check({v.name, "_latency"}, 32'(acc_valid), 32'd1);
      check({v.name, "_done"}, 32'(dbg_state), 32'(S_DONE));
      step();
      check({v.name, "_back_idle"}, 32'(dbg_state), 32'(S_IDLE));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{"v_basic",   3, '{100, -50, 7, 0, 0, 0, 0, 0, 0, 0}, 1'b0, 57, 1'b0};
      vecs[1] = '{"v_toggle",  4, '{16384, 16384, 16384, 16384, 0, 0, 0, 0, 0, 0}, 1'b1, 65536, 1'b0};
      vecs[2] = '{"v_sat_pos", 9, '{16384, 16384, 16384, 16384, 16384, 16384, 16384, 16384, 16384, 0},
                  1'b0, 131071, 1'b1};
      vecs[3] = '{"v_sat_neg", 9, '{-16384, -16384, -16384, -16384, -16384, -16384, -16384, -16384, -16384, 0},
                  1'b0, -131072, 1'b1};
      vecs[4] = '{"v_sat_recover", 10, '{16384, 16384, 16384, 16384, 16384, 16384, 16384, 16384, -16384, -16384},
                  1'b0, 98303, 1'b1};
      vecs[5] = '{"v_extremes", 2, '{-32768, 32767, 0, 0, 0, 0, 0, 0, 0, 0}, 1'b1, -1, 1'b0};

      repeat (3) step();
      check("rst_acc", 32'(acc_out), 32'd0);
      check("rst_ovf", 32'(acc_ovf), 32'd0);
      check("rst_valid", 32'(acc_valid), 32'd0);
      check("rst_ready", 32'(prod_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(S_IDLE));
      rst_n = 1'b1;

      // A product offered in IDLE must not be taken.
      prod = PW'(123);
      prod_valid = 1'b1;
      step();
      check("idle_no_ready", 32'(prod_ready), 32'd0);
      check("idle_stays", 32'(dbg_state), 32'(S_IDLE));
      prod_valid = 1'b0;

      foreach (vecs[i]) run_vec(vecs[i]);

      // len=0: result 0 next cycle, held under backpressure.
      acc_ready = 1'b0;
      start = 1'b1;
      len = '0;
      step();
      start = 1'b0;
      check("len0_valid", 32'(acc_valid), 32'd1);
      check("len0_acc", 32'(acc_out), 32'd0);
      exp_q.push_back(mk_exp(0, 1'b0));
      acc_ready = 1'b1;
      step();
      check("len0_idle", 32'(dbg_state), 32'(S_IDLE));

      // Backpressure on a nonzero result plus start ignored in DONE.
      acc_ready = 1'b0;
      start = 1'b1;
      len = LW'(1);
      step();
      start = 1'b0;
      prod = PW'(1234);
      prod_valid = 1'b1;
      step();
      prod_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (k == 2) begin
            start = 1'b1;
            len = LW'(3);
         end
         step();
         start = 1'b0;
         check("hold_valid", 32'(acc_valid), 32'd1);
         check("hold_acc", 32'(acc_out), accv(1234));
         check("hold_state", 32'(dbg_state), 32'(S_DONE));
      end
      exp_q.push_back(mk_exp(1234, 1'b0));
      acc_ready = 1'b1;
      step();
      check("hold_idle", 32'(dbg_state), 32'(S_IDLE));

      // Clear mid-run.
      start = 1'b1;
      len = LW'(5);
      step();
      start = 1'b0;
      prod_valid = 1'b1;
      prod = PW'(10);
      step();
      prod = PW'(20);
      step();
      prod_valid = 1'b0;
      check("pre_clear_acc", 32'(acc_out), accv(30));
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("clear_state", 32'(dbg_state), 32'(S_IDLE));
      check("clear_acc", 32'(acc_out), 32'd0);
      check("clear_valid", 32'(acc_valid), 32'd0);

      // Clear and start together: clear wins.
      clear = 1'b1;
      start = 1'b1;
      len = LW'(2);
      step();
      clear = 1'b0;
      start = 1'b0;
      check("clr_start_state", 32'(dbg_state), 32'(S_IDLE));
      check("clr_start_busy", 32'(busy), 32'd0);
      step();
      check("clr_start_valid", 32'(acc_valid), 32'd0);

      // Clear in DONE discards the result.
      acc_ready = 1'b0;
      start = 1'b1;
      len = LW'(1);
      step();
      start = 1'b0;
      prod_valid = 1'b1;
      prod = PW'(5);
      step();
      prod_valid = 1'b0;
      check("done_before_clear", 32'(acc_valid), 32'd1);
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("done_clear_valid", 32'(acc_valid), 32'd0);
      check("done_clear_acc", 32'(acc_out), 32'd0);
      acc_ready = 1'b1;

      // Reset mid-run.
      start = 1'b1;
      len = LW'(3);
      step();
      start = 1'b0;
      prod_valid = 1'b1;
      prod = PW'(77);
      step();
      prod_valid = 1'b0;
      check("pre_rst_acc", 32'(acc_out), accv(77));
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("midrst_state", 32'(dbg_state), 32'(S_IDLE));
      check("midrst_acc", 32'(acc_out), 32'd0);
      check("midrst_ovf", 32'(acc_ovf), 32'd0);
      check("midrst_valid", 32'(acc_valid), 32'd0);
      check("midrst_ready", 32'(prod_ready), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      step();
      step();

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
